// File: rtl/sensor_responder_if.sv
// Serial link and sensor-side signals of the polled sensor responder.
// The slave modport is the responder's view; master is the arbitrator/bench.
interface sensor_responder_if;
  logic       rx;
  logic       tx;
  logic [7:0] sensor_data;
  logic       busy;
  logic       frame_err;
  logic [7:0] poll_count;

  modport slave (
    input  rx, sensor_data,
    output tx, busy, frame_err, poll_count
  );

  modport master (
    output rx, sensor_data,
    input  tx, busy, frame_err, poll_count
  );
endinterface

// File: rtl/sensor_responder.sv
// Half-duplex UART poll responder: receives an address byte, and on a match answers
// with the latched sensor sample followed by its CRC-8 (poly 0x07), back-to-back.
module sensor_responder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [2:0]  SENSOR_ID    = 3'd1
) (
  input logic          clock,
  input logic          reset,
  sensor_responder_if.slave bus
);
  localparam int unsigned TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, RX_START, RX_DATA, RX_STOP, TX_DATA, TX_CRC
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic          armed_q, armed_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    poll_q, poll_d;
  logic          ferr_q, ferr_d;
  logic          tick, stop_good, addr_hit, latch;
  logic          tx_o, busy_o;
  logic [7:0]    tx_byte;

  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  assign rx_s = sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.rx};
  end

  // Start bit is resampled at half a bit; everything else lands on full-bit ticks.
  always_comb begin
    tick = (state_q == RX_START) ? (timer_q == HALF_END) : (timer_q == BIT_END);
  end

  assign stop_good = (state_q == RX_STOP) && tick && rx_s;
  assign addr_hit  = (shift_q[2:0] == SENSOR_ID);
  assign latch     = stop_good && addr_hit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (armed_q && !rx_s) state_d = RX_START;
      RX_START: if (tick) state_d = rx_s ? IDLE : RX_DATA;
      RX_DATA:  if (tick && bitcnt_q == 4'd7) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = latch ? TX_DATA : IDLE;
      TX_DATA:  if (tick && bitcnt_q == 4'd9) state_d = TX_CRC;
      TX_CRC:   if (tick && bitcnt_q == 4'd9) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    tx_byte = (state_q == TX_CRC) ? crc_q : data_q;
    tx_o    = 1'b1;
    busy_o  = 1'b0;
    if (state_q == TX_DATA || state_q == TX_CRC) begin
      busy_o = 1'b1;
      if (bitcnt_q == 4'd0)      tx_o = 1'b0;
      else if (bitcnt_q <= 4'd8) tx_o = tx_byte[bitcnt_q[2:0] - 3'd1];
      else                       tx_o = 1'b1;
    end
  end

  assign bus.tx         = tx_o;
  assign bus.busy       = busy_o;
  assign bus.frame_err  = ferr_q;
  assign bus.poll_count = poll_q;

  // ---------------- datapath next state ----------------
  always_comb begin
    timer_d  = (state_q == IDLE || state_d != state_q || tick) ? '0 : timer_q + 1'b1;
    bitcnt_d = bitcnt_q;
    if (state_d != state_q)
      bitcnt_d = 4'd0;
    else if (tick && (state_q == RX_DATA || state_q == TX_DATA || state_q == TX_CRC))
      bitcnt_d = bitcnt_q + 4'd1;

    shift_d = shift_q;
    if (state_q == RX_DATA && tick) shift_d = {rx_s, shift_q[7:1]};

    // A new start edge only counts after rx has been seen idle-high inside IDLE.
    armed_d = (state_q == IDLE) && (state_d == IDLE) && (armed_q || rx_s);

    data_d = data_q;
    crc_d  = crc_q;
    poll_d = poll_q;
    if (latch) begin
      data_d = bus.sensor_data;
      crc_d  = crc8(bus.sensor_data);
      poll_d = poll_q + 8'd1;
    end

    ferr_d = (state_q == RX_STOP) && tick && !rx_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      armed_q  <= 1'b0;
      data_q   <= '0;
      crc_q    <= '0;
      poll_q   <= '0;
      ferr_q   <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      data_q   <= data_d;
      crc_q    <= crc_d;
      poll_q   <= poll_d;
      ferr_q   <= ferr_d;
    end
  end
endmodule

// File: tb/tb_sensor_responder.sv
// Directed plus randomized polls against a reference model of the responder protocol.
module tb_sensor_responder;
  localparam int         CPB = 16;
  localparam logic [2:0] ID  = 3'd1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sensor_responder_if bus();

  sensor_responder #(.CLKS_PER_BIT(CPB), .SENSOR_ID(ID)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // free-running observation counters, sampled on the falling edge
  int   cyc_n = 0, busy_cnt = 0, fe_cyc = 0, fe_pulses = 0, tx_low = 0;
  logic fe_prev = 1'b0;
  always @(negedge clock) begin
    cyc_n   <= cyc_n + 1;
    fe_prev <= bus.frame_err;
    if (bus.busy === 1'b1)      busy_cnt <= busy_cnt + 1;
    if (bus.frame_err === 1'b1) fe_cyc   <= fe_cyc + 1;
    if (bus.frame_err === 1'b1 && fe_prev !== 1'b1) fe_pulses <= fe_pulses + 1;
    if (bus.tx === 1'b0)        tx_low   <= tx_low + 1;
  end

  // UART decoder on tx; frames touched by reset are dropped
  logic [7:0] byte_log [0:255];
  int         byte_t   [0:255];
  int         n_bytes = 0;
  logic [7:0] m_b;
  logic       m_ok;
  int         m_t;
  always begin
    @(negedge clock);
    if (!reset && bus.tx === 1'b0) begin
      m_t  = cyc_n;
      m_ok = 1'b1;
      m_b  = 8'h00;
      for (int c = 0; c < CPB / 2; c++) begin @(negedge clock); if (reset) m_ok = 1'b0; end
      if (bus.tx !== 1'b0) m_ok = 1'b0;
      for (int i = 0; i < 9; i++) begin
        for (int c = 0; c < CPB; c++) begin @(negedge clock); if (reset) m_ok = 1'b0; end
        if (i < 8) m_b[i] = bus.tx;
        else if (bus.tx !== 1'b1) m_ok = 1'b0;
      end
      if (m_ok) begin
        byte_log[n_bytes[7:0]] = m_b;
        byte_t[n_bytes[7:0]]   = m_t;
        n_bytes++;
      end
    end
  end

  // CRC as the remainder of d*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    bus.rx = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin bus.rx = b[i]; cyc(CPB); end
    bus.rx = good_stop; cyc(CPB);
  endtask

  logic [7:0] pc_exp = 8'd0;

  task automatic poll(input logic [7:0] sel, input logic [7:0] sd, input bit noise);
    int nb, bc, tl, k;
    nb = n_bytes; bc = busy_cnt; tl = tx_low;
    bus.sensor_data = sd;
    send_byte(sel, 1'b1);
    if (sel[2:0] == ID) begin
      pc_exp = pc_exp + 8'd1;
      if (noise) begin
        for (int i = 0; i < 150; i++) begin
          bus.rx = 1'($urandom);
          bus.sensor_data = 8'($urandom);
          cyc(1);
        end
        bus.rx = 1'b1;
      end
      k = 0;
      while (bus.busy !== 1'b0 && k < 600) begin cyc(1); k++; end
      chk("resp_timeout", 32'(k < 600), 32'd1);
      cyc(10);
      chk("resp_count", n_bytes - nb, 2);
      chk("resp_data", byte_log[nb[7:0]], sd);
      chk("resp_crc", byte_log[8'(nb + 1)], crc_ref(sd));
      chk("resp_gap", byte_t[8'(nb + 1)] - byte_t[nb[7:0]], 10 * CPB);
      chk("busy_cycles", busy_cnt - bc, 20 * CPB);
    end else begin
      cyc(60);
      chk("no_resp_bytes", n_bytes - nb, 0);
      chk("no_resp_txlow", tx_low - tl, 0);
    end
    chk("poll_count", bus.poll_count, pc_exp);
    cyc(10);
  endtask

  initial begin
    int nb, fp, fc, tl;
    logic [7:0] sel, sd;
    bus.rx = 1'b1;
    bus.sensor_data = 8'h00;
    cyc(3);
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_poll", bus.poll_count, 0);
    reset = 1'b0;
    cyc(5);

    poll(8'h01, 8'h80, 1'b0);
    chk("crc_0x80", byte_log[1], 8'h89);
    poll(8'h02, 8'h55, 1'b0);
    poll(8'h00, 8'h55, 1'b0);
    poll(8'hF9, 8'h01, 1'b0);
    chk("crc_0x01", byte_log[3], 8'h07);

    // bad stop bit
    nb = n_bytes; fp = fe_pulses; fc = fe_cyc;
    send_byte(8'h01, 1'b0);
    bus.rx = 1'b1;
    cyc(40);
    chk("ferr_pulses", fe_pulses - fp, 1);
    chk("ferr_width", fe_cyc - fc, 1);
    chk("ferr_no_resp", n_bytes - nb, 0);
    chk("ferr_poll", bus.poll_count, pc_exp);

    // short low glitch while idle
    nb = n_bytes; fp = fe_pulses;
    bus.rx = 1'b0; cyc(4); bus.rx = 1'b1;
    cyc(40);
    chk("glitch_ferr", fe_pulses - fp, 0);
    chk("glitch_no_resp", n_bytes - nb, 0);
    poll(8'h01, 8'h3C, 1'b0);

    // random addresses and samples, rx noise and sensor churn during the response
    for (int i = 0; i < 8; i++) begin
      sel = 8'($urandom);
      if (i % 2 == 0) sel[2:0] = ID;
      sd = 8'($urandom);
      poll(sel, sd, 1'b1);
    end

    // reset in the middle of the data frame
    bus.sensor_data = 8'h5A;
    send_byte(8'h01, 1'b1);
    chk("tx_started", bus.busy, 1);
    cyc(5 * CPB);
    reset = 1'b1;
    #1;
    chk("abort_tx", bus.tx, 1);
    chk("abort_busy", bus.busy, 0);
    cyc(3);
    chk("abort_poll", bus.poll_count, 0);
    reset = 1'b0;
    pc_exp = 8'd0;
    nb = n_bytes; tl = tx_low;
    cyc(400);
    chk("abort_no_crc", n_bytes - nb, 0);
    chk("abort_tx_idle", tx_low - tl, 0);
    poll(8'h01, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sensor_responder.md
SENSOR_RESPONDER -- requirements
Module: sensor_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200); legal minimum 8.
REQ-002 SHALL have parameter SENSOR_ID, default 3'd1, meaning the 3-bit poll address this responder answers; legal range 1..6.
REQ-003 SHALL have port clock  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, which is asynchronous and active-high.
REQ-005 SHALL have port rx  input  1  meaning serial line from the polling arbitrator (8N1, LSB first, idle high, asynchronous to clock).
REQ-006 SHALL have port tx  output  1  meaning serial response line to the arbitrator (8N1, LSB first, idle high).
REQ-007 SHALL have port sensor_data  input  8  meaning the current sensor sample.
REQ-008 SHALL have port busy  output  1  meaning high while a response frame pair is being transmitted.
REQ-009 SHALL have port frame_err  output  1  meaning a one-cycle pulse on a received byte with a bad stop bit.
REQ-010 SHALL have port poll_count  output  8  meaning the count of polls addressed to this responder.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-012 SHALL implement one FSM with states IDLE, RX_START, RX_DATA, RX_STOP, TX_DATA and TX_CRC; the link is half-duplex.
REQ-013 IDLE: a synchronized rx 1->0 transition SHALL move the FSM to RX_START and clear the bit-timer.
REQ-014 RX_START: at CLKS_PER_BIT/2 cycles the FSM SHALL resample rx; if rx is low, go to RX_DATA; if high (glitch), return to IDLE with no frame_err.
REQ-015 RX_DATA: the FSM SHALL sample 8 bits, each exactly CLKS_PER_BIT cycles apart, LSB first into a shift register, then enter RX_STOP.
REQ-016 RX_STOP: after CLKS_PER_BIT cycles the FSM SHALL sample rx; if low, pulse frame_err for 1 cycle, discard the byte and go to IDLE.
REQ-017 On a valid stop bit with byte[2:0]==SENSOR_ID, the FSM SHALL ignore byte[7:3], latch sensor_data into the data register in that same cycle, increment poll_count and enter TX_DATA on the next cycle.
REQ-018 poll_count SHALL wrap from 255 to 0.
REQ-019 On a valid stop bit with byte[2:0]!=SENSOR_ID, including 0 and 7, the FSM SHALL return to IDLE silently.
REQ-020 The CRC byte SHALL be CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over the latched data byte; it SHALL be ready before TX_CRC begins.
REQ-021 TX_DATA and TX_CRC SHALL each send 10 bit-times of CLKS_PER_BIT cycles: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-022 TX_CRC SHALL start in the cycle immediately after the TX_DATA stop bit ends, so the gap between the two frames is 0 cycles.
REQ-023 The first tx start bit SHALL begin no more than 2 clock cycles after the received stop-bit sample.
REQ-024 busy SHALL be 1 from TX_DATA entry until the end of the TX_CRC stop bit, then 0 in IDLE.
REQ-025 rx activity during TX_DATA or TX_CRC SHALL be ignored.
REQ-026 After TX_CRC, IDLE SHALL require synchronized rx to be seen high for at least 1 cycle before accepting a new falling edge.
REQ-027 Changes on sensor_data after the latch cycle SHALL NOT affect the frame pair in progress.
REQ-028 tx SHALL be 1 in every state other than TX_DATA and TX_CRC.

Reset
REQ-029 While reset=1, the block SHALL force, asynchronously: state=IDLE, tx=1, busy=0, frame_err=0, poll_count=0, bit-timer and bit-count=0, data and CRC registers=0, synchronizer=1.
REQ-030 Reset asserted mid-reception or mid-transmission SHALL abort the frame immediately with tx=1 and SHALL NOT emit a partial CRC byte after release.
REQ-031 After reset deassertion, the block SHALL accept a new poll starting at the next valid falling edge.

Verification (CLKS_PER_BIT=16, SENSOR_ID=1)
REQ-032 Bench SHALL drive select byte 0x01 with sensor_data=0x80 -> tx carries 0x80 then 0x89, back-to-back; poll_count=1; busy high for exactly 320 cycles.
REQ-033 Bench SHALL send select byte 0x02, then 0x00 -> tx stays 1 throughout; poll_count unchanged.
REQ-034 Bench SHALL send select byte 0xF9 (bits[2:0]=1) with sensor_data=0x01 -> response 0x01 then 0x07.
REQ-035 Bench SHALL send byte 0x01 with its stop bit forced 0 -> frame_err pulses 1 cycle; no response; poll_count unchanged.
REQ-036 Bench SHALL drive a 4-cycle low glitch on rx in IDLE -> no frame_err and no response; a following valid 0x01 poll is answered normally.
REQ-037 Bench SHALL assert reset 5 bit-times into TX_DATA -> tx=1 and busy=0 immediately; no CRC byte after release; poll_count=0; the next poll with sensor_data=0x00 returns 0x00, 0x00.
